// File: rtl/adder_serial_n.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-bit slice per cycle through a
// ripple chain of full-adder cells, carry held in a register between slices.

module adder_serial_n_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end
endmodule

module adder_serial_n #(
    parameter int N     = 32,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    input  logic         i_valid,
    output logic         i_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         overflow,
    output logic         o_valid,
    input  logic         o_ready
);
    localparam int L  = N / CHUNK;
    localparam int CW = (L > 1) ? $clog2(L) : 1;

    generate
        if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_param_check
            $error("adder_serial_n: need 1 <= CHUNK <= N and N %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;
    logic [N-1:0]   acc;
    logic [N-1:0]   acc_next;
    logic           carry;
    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic [CHUNK:0]   chain;
    logic           accept;
    logic           last;

    assign i_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign accept  = i_valid && (state == IDLE);
    assign last    = (cnt == CW'(L - 1));

    always_comb begin
        slice_a = a_reg[int'(cnt) * CHUNK +: CHUNK];
        slice_b = b_reg[int'(cnt) * CHUNK +: CHUNK];
    end

    assign chain[0] = carry;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_cell
            adder_serial_n_fa u_fa (
                .a  (slice_a[i]),
                .b  (slice_b[i]),
                .ci (chain[i]),
                .s  (slice_sum[i]),
                .co (chain[i+1])
            );
        end
    endgenerate

    // Merge the current slice so the last BUSY edge can publish the full word at once.
    always_comb begin
        acc_next = acc;
        acc_next[int'(cnt) * CHUNK +: CHUNK] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last) state_next = DONE;
            DONE: if (o_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtraction as a + ~b + ~c_in; c_out then reads 1 for "no borrow".
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? ~c_in : c_in;
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc   <= acc_next;
            carry <= chain[CHUNK];
            if (last) begin
                cnt      <= '0;
                sum      <= acc_next;
                c_out    <= chain[CHUNK];
                overflow <= chain[CHUNK] ^ chain[CHUNK-1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_adder_serial_n.sv
// Directed table, handshake/reset sequences and random ops for adder_serial_n
// at (N,CHUNK) = (8,2) and (8,8).

module tb_adder_serial_n;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       c_in = 1'b0;
    logic       sub = 1'b0;
    logic       i_valid0 = 1'b0;
    logic       i_valid1 = 1'b0;
    logic       o_ready = 1'b0;
    logic       i_ready0, i_ready1, o_valid0, o_valid1;
    logic [7:0] sum0, sum1;
    logic       c_out0, c_out1, ovf0, ovf1;

    int tests = 0;
    int fails = 0;
    int sel = 0;

    logic       cur_iready, cur_ovalid, cur_cout, cur_ovf;
    logic [7:0] cur_sum;

    always #5 clk = ~clk;

    adder_serial_n #(.N(8), .CHUNK(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .i_valid(i_valid0), .i_ready(i_ready0), .sum(sum0), .c_out(c_out0),
        .overflow(ovf0), .o_valid(o_valid0), .o_ready(o_ready)
    );

    adder_serial_n #(.N(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .sub(sub),
        .i_valid(i_valid1), .i_ready(i_ready1), .sum(sum1), .c_out(c_out1),
        .overflow(ovf1), .o_valid(o_valid1), .o_ready(o_ready)
    );

    always_comb begin
        cur_iready = (sel == 0) ? i_ready0 : i_ready1;
        cur_ovalid = (sel == 0) ? o_valid0 : o_valid1;
        cur_sum    = (sel == 0) ? sum0 : sum1;
        cur_cout   = (sel == 0) ? c_out0 : c_out1;
        cur_ovf    = (sel == 0) ? ovf0 : ovf1;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Issue one op on the selected DUT, check latency and that outputs hold while
    // waiting; optionally keep o_ready low for 'hold' cycles with junk i_valid pulses.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                          input logic sb, input int hold, input bit noise,
                          output logic [7:0] rs, output logic rc, output logic ro);
        int lat;
        logic [7:0] prev;
        @(negedge clk);
        chk("i_ready_idle", cur_iready, 1);
        prev = cur_sum;
        a = av; b = bv; c_in = ci; sub = sb;
        if (sel == 0) i_valid0 = 1'b1; else i_valid1 = 1'b1;
        @(negedge clk);
        i_valid0 = 1'b0; i_valid1 = 1'b0;
        lat = 0;
        while (!cur_ovalid && lat < 20) begin
            chk("sum_hold_busy", cur_sum, prev);
            chk("i_ready_busy", cur_iready, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, (sel == 0) ? 4 : 1);
        rs = cur_sum; rc = cur_cout; ro = cur_ovf;
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                a = ~av; b = ~bv; c_in = ~ci; sub = ~sb;
                if (sel == 0) i_valid0 = 1'b1; else i_valid1 = 1'b1;
            end
            @(negedge clk);
            chk("bp_o_valid", cur_ovalid, 1);
            chk("bp_i_ready", cur_iready, 0);
            chk("bp_stable", {cur_sum, cur_cout, cur_ovf}, {rs, rc, ro});
        end
        i_valid0 = 1'b0; i_valid1 = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk("o_valid_drop", cur_ovalid, 0);
        chk("i_ready_after", cur_iready, 1);
        chk("post_hs_hold", {cur_sum, cur_cout, cur_ovf}, {rs, rc, ro});
    endtask

    function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                          input logic ci, input logic sb);
        logic [8:0] wide;
        int sa, sbv, res;
        logic ov;
        wide = sb ? ({1'b0, av} + {1'b0, ~bv} + {8'd0, ~ci})
                  : ({1'b0, av} + {1'b0, bv} + {8'd0, ci});
        sa  = int'($signed(av));
        sbv = int'($signed(bv));
        res = sb ? (sa - sbv - int'(ci)) : (sa + sbv + int'(ci));
        ov  = (res > 127) || (res < -128);
        return {ov, wide};
    endfunction

    initial begin
        logic [7:0] rs;
        logic rc, ro;
        logic [7:0] ra, rb;
        logic rci, rsb;
        logic [9:0] exp;

        vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vt[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vt[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vt[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[5]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vt[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[9]  = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1};
        vt[10] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0};

        #12;
        chk("rst_sum", sum0, 8'h00);
        chk("rst_cout", c_out0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_o_valid", o_valid0, 0);
        chk("rst_i_ready", i_ready0, 1);
        chk("rst_o_valid_l1", o_valid1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 11; i++) begin
                run_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, 0, 1'b0, rs, rc, ro);
                chk($sformatf("vec%0d_sum_d%0d", i, s), rs, vt[i].s);
                chk($sformatf("vec%0d_cout_d%0d", i, s), rc, vt[i].co);
                chk($sformatf("vec%0d_ovf_d%0d", i, s), ro, vt[i].ov);
            end
        end

        // Backpressure with junk input pulses, then a follow-up op.
        sel = 0;
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 5, 1'b1, rs, rc, ro);
        chk("bp_sum", {rc, ro, rs}, {1'b0, 1'b0, 8'h46});
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0, rs, rc, ro);
        chk("bp_next_sum", {rc, ro, rs}, {1'b0, 1'b0, 8'hFE});

        // Reset two cycles into BUSY.
        @(negedge clk);
        a = 8'h3C; b = 8'h0F; c_in = 1'b0; sub = 1'b0;
        i_valid0 = 1'b1;
        @(negedge clk);
        i_valid0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_sum", sum0, 8'h00);
        chk("midrst_o_valid", o_valid0, 0);
        chk("midrst_cout", c_out0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_i_ready", i_ready0, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_emit", o_valid0, 0);
        end
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 0, 1'b0, rs, rc, ro);
        chk("midrst_next", {rc, ro, rs}, {1'b0, 1'b1, 8'h80});

        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 200; i++) begin
                ra = 8'($urandom); rb = 8'($urandom);
                rci = 1'($urandom); rsb = 1'($urandom);
                exp = model(ra, rb, rci, rsb);
                run_op(ra, rb, rci, rsb, int'($urandom_range(0, 3)), 1'b0, rs, rc, ro);
                chk($sformatf("rnd_d%0d_%0h_%0h_%0b_%0b", s, ra, rb, rci, rsb),
                    {ro, rc, rs}, exp);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
